// File: rtl/pe_feeder_pkg.sv
// rtl/pe_feeder_pkg.sv - shared FSM encodings and beat constants for pe_feeder
package pe_feeder_pkg;

   localparam int MAC_DIM = 4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WLOAD = 2'd1;
   localparam logic [1:0] S_FEAT  = 2'd2;

   // non_zero_num carries count-1; an empty beat still reports 0
   function automatic logic [1:0] nzn_enc(input logic [2:0] count);
      return (count == 3'd0) ? 2'd0 : 2'(count - 3'd1);
   endfunction

endpackage

// File: rtl/pe_feeder_nz_extract4.sv
// rtl/pe_feeder_nz_extract4.sv - pulls the lowest four set bits out of a mask
module nz_extract4
   import pe_feeder_pkg::*;
#(
   parameter  int SPAD_WIDTH = 64,
   localparam int ADDR_WIDTH = $clog2(SPAD_WIDTH)
) (
   input  logic [SPAD_WIDTH-1:0]               mask_i,
   output logic [MAC_DIM-1:0][ADDR_WIDTH-1:0]  idx_o,
   output logic [2:0]                          count_o,
   output logic [SPAD_WIDTH-1:0]               next_mask_o
);

   logic [SPAD_WIDTH-1:0] m;

   // Each stage finds the lowest set bit, then m & (m-1) strips it for the next stage
   always_comb begin
      m       = mask_i;
      idx_o   = '0;
      count_o = '0;
      for (int k = 0; k < MAC_DIM; k++) begin
         for (int b = SPAD_WIDTH - 1; b >= 0; b--) begin
            if (m[b]) idx_o[k] = ADDR_WIDTH'(b);
         end
         if (m != '0) count_o = count_o + 3'd1;
         m = m & (m - SPAD_WIDTH'(1));
      end
      next_mask_o = m;
   end

endmodule

// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - loads PE weight scratchpad, then streams sparse feature-row beats
module pe_feeder
   import pe_feeder_pkg::*;
#(
   parameter  int WGT_WIDTH  = 8,
   parameter  int SPAD_WIDTH = 64,
   parameter  int NUM_NODES  = 20,
   localparam int ADDR_WIDTH = $clog2(SPAD_WIDTH),
   localparam int WGT_INDEX  = $clog2(WGT_WIDTH),
   localparam int NODE_W     = $clog2(NUM_NODES) + 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [NODE_W-1:0]             num_rows,
   input  logic                          w_valid,
   input  logic [SPAD_WIDTH-1:0]         w_data,
   output logic                          w_ready,
   input  logic                          f_valid,
   input  logic [SPAD_WIDTH-1:0]         f_data,
   output logic                          f_ready,
   output logic [ADDR_WIDTH*MAC_DIM-1:0] addr_bus,
   output logic [SPAD_WIDTH-1:0]         data_bus,
   output logic [1:0]                    non_zero_num,
   output logic                          acc,
   output logic                          done,
   output logic                          w_we,
   output logic                          x_we,
   output logic                          busy,
   output logic                          job_done
);

   logic [1:0]                    state_q, state_d;
   logic [WGT_INDEX-1:0]          wcnt_q, wcnt_d;
   logic [NODE_W-1:0]             rcnt_q, rcnt_d, nrows_q, nrows_d;
   logic [SPAD_WIDTH-1:0]         mask_q, mask_d, row_q, row_d;
   logic                          pend_q, pend_d;
   logic [ADDR_WIDTH*MAC_DIM-1:0] addr_q, addr_d;
   logic [SPAD_WIDTH-1:0]         data_q, data_d;
   logic [1:0]                    nzn_q, nzn_d;
   logic                          acc_q, acc_d, done_q, done_d;
   logic                          w_we_q, w_we_d, x_we_q, x_we_d;
   logic                          w_ready_q, w_ready_d, f_ready_q, f_ready_d;
   logic                          job_done_q, job_done_d;

   logic                                w_hs, f_hs;
   logic [SPAD_WIDTH-1:0]               ext_src, ext_next;
   logic [MAC_DIM-1:0][ADDR_WIDTH-1:0]  ext_idx;
   logic [2:0]                          ext_cnt;

   assign w_hs = w_valid & w_ready_q;
   assign f_hs = f_valid & f_ready_q;
   // The first beat of a row is extracted straight from f_data so it lands one cycle after the handshake
   assign ext_src = pend_q ? mask_q : f_data;

   nz_extract4 #(.SPAD_WIDTH(SPAD_WIDTH)) u_extract (
      .mask_i      (ext_src),
      .idx_o       (ext_idx),
      .count_o     (ext_cnt),
      .next_mask_o (ext_next)
   );

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      rcnt_d     = rcnt_q;
      nrows_d    = nrows_q;
      mask_d     = mask_q;
      row_d      = row_q;
      pend_d     = pend_q;
      addr_d     = addr_q;
      data_d     = data_q;
      nzn_d      = nzn_q;
      acc_d      = acc_q;
      done_d     = done_q;
      w_ready_d  = w_ready_q;
      f_ready_d  = f_ready_q;
      w_we_d     = 1'b0;
      x_we_d     = 1'b0;
      job_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               nrows_d = num_rows;
               wcnt_d  = '0;
               rcnt_d  = '0;
               pend_d  = 1'b0;
               mask_d  = '0;
               if (num_rows == '0) begin
                  job_done_d = 1'b1;
               end else begin
                  state_d   = S_WLOAD;
                  w_ready_d = 1'b1;
               end
            end
         end
         S_WLOAD: begin
            if (w_hs) begin
               w_we_d                 = 1'b1;
               data_d                 = w_data;
               addr_d                 = '0;
               addr_d[WGT_INDEX-1:0]  = wcnt_q;
               wcnt_d                 = wcnt_q + WGT_INDEX'(1);
               if (wcnt_q == WGT_INDEX'(WGT_WIDTH - 1)) begin
                  state_d   = S_FEAT;
                  w_ready_d = 1'b0;
                  f_ready_d = 1'b1;
               end
            end
         end
         S_FEAT: begin
            if (pend_q || f_hs) begin
               x_we_d    = 1'b1;
               addr_d    = ext_idx;
               data_d    = pend_q ? row_q : f_data;
               row_d     = pend_q ? row_q : f_data;
               nzn_d     = nzn_enc(ext_cnt);
               acc_d     = pend_q;
               done_d    = (ext_next == '0);
               mask_d    = ext_next;
               pend_d    = (ext_next != '0);
               f_ready_d = 1'b0;
               if (ext_next == '0) rcnt_d = rcnt_q + NODE_W'(1);
            end else if (rcnt_q == nrows_q) begin
               state_d    = S_IDLE;
               job_done_d = 1'b1;
               f_ready_d  = 1'b0;
            end else begin
               f_ready_d = 1'b1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            w_ready_d = 1'b0;
            f_ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         wcnt_q     <= '0;
         rcnt_q     <= '0;
         nrows_q    <= '0;
         mask_q     <= '0;
         row_q      <= '0;
         pend_q     <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         nzn_q      <= '0;
         acc_q      <= 1'b0;
         done_q     <= 1'b0;
         w_we_q     <= 1'b0;
         x_we_q     <= 1'b0;
         w_ready_q  <= 1'b0;
         f_ready_q  <= 1'b0;
         job_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         rcnt_q     <= rcnt_d;
         nrows_q    <= nrows_d;
         mask_q     <= mask_d;
         row_q      <= row_d;
         pend_q     <= pend_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         nzn_q      <= nzn_d;
         acc_q      <= acc_d;
         done_q     <= done_d;
         w_we_q     <= w_we_d;
         x_we_q     <= x_we_d;
         w_ready_q  <= w_ready_d;
         f_ready_q  <= f_ready_d;
         job_done_q <= job_done_d;
      end
   end

   assign w_ready      = w_ready_q;
   assign f_ready      = f_ready_q;
   assign addr_bus     = addr_q;
   assign data_bus     = data_q;
   assign non_zero_num = nzn_q;
   assign acc          = acc_q;
   assign done         = done_q;
   assign w_we         = w_we_q;
   assign x_we         = x_we_q;
   assign busy         = (state_q != S_IDLE);
   assign job_done     = job_done_q;

endmodule

// File: tb/tb_pe_feeder.sv
// tb/tb_pe_feeder.sv - directed self-checking bench for pe_feeder
module tb_pe_feeder;

   localparam logic [63:0] W_BASE = 64'h0807060504030201;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  num_rows;
   logic        w_valid;
   logic [63:0] w_data;
   logic        w_ready;
   logic        f_valid;
   logic [63:0] f_data;
   logic        f_ready;
   logic [23:0] addr_bus;
   logic [63:0] data_bus;
   logic [1:0]  non_zero_num;
   logic        acc, done, w_we, x_we, busy, job_done;

   int n_pass  = 0;
   int n_total = 0;

   pe_feeder dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .num_rows     (num_rows),
      .w_valid      (w_valid),
      .w_data       (w_data),
      .w_ready      (w_ready),
      .f_valid      (f_valid),
      .f_data       (f_data),
      .f_ready      (f_ready),
      .addr_bus     (addr_bus),
      .data_bus     (data_bus),
      .non_zero_num (non_zero_num),
      .acc          (acc),
      .done         (done),
      .w_we         (w_we),
      .x_we         (x_we),
      .busy         (busy),
      .job_done     (job_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [23:0] mk(input int s0, input int s1, input int s2, input int s3);
      return {6'(s3), 6'(s2), 6'(s1), 6'(s0)};
   endfunction

   task automatic chk_beat(input string tag, input logic [23:0] a, input logic [63:0] row,
                           input logic [1:0] nzn, input logic ac, input logic dn);
      chk({tag, "_x_we"}, 64'(x_we), 64'd1);
      chk({tag, "_w_we"}, 64'(w_we), 64'd0);
      chk({tag, "_addr"}, 64'(addr_bus), 64'(a));
      chk({tag, "_data"}, data_bus, row);
      chk({tag, "_nzn"},  64'(non_zero_num), 64'(nzn));
      chk({tag, "_acc"},  64'(acc), 64'(ac));
      chk({tag, "_done"}, 64'(done), 64'(dn));
   endtask

   task automatic start_job(input logic [5:0] n);
      start    = 1'b1;
      num_rows = n;
      tick;
      start    = 1'b0;
   endtask

   task automatic load_w(input bit gaps);
      for (int i = 0; i < 8; i++) begin
         if (gaps) begin
            w_valid = 1'b0;
            tick;
            chk("w_gap_we", 64'(w_we), 64'd0);
         end
         w_valid = 1'b1;
         w_data  = W_BASE + 64'(i);
         tick;
         chk("w_we", 64'(w_we), 64'd1);
         chk("w_x_we", 64'(x_we), 64'd0);
         chk("w_addr", 64'(addr_bus), 64'(i));
         chk("w_data", data_bus, W_BASE + 64'(i));
      end
      w_valid = 1'b0;
      chk("w_ready_after", 64'(w_ready), 64'd0);
      chk("f_ready_after_w", 64'(f_ready), 64'd1);
   endtask

   task automatic send_row(input logic [63:0] d);
      bit hit = 1'b0;
      f_valid = 1'b1;
      f_data  = d;
      for (int c = 0; c < 40 && !hit; c++) begin
         if (f_ready === 1'b1) hit = 1'b1;
         tick;
      end
      f_valid = 1'b0;
      if (!hit) chk("f_ready_timeout", 64'(f_ready), 64'd1);
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      num_rows = '0;
      w_valid  = 1'b0;
      w_data   = '0;
      f_valid  = 1'b0;
      f_data   = '0;
      tick;
      tick;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_w_ready", 64'(w_ready), 64'd0);
      chk("rst_f_ready", 64'(f_ready), 64'd0);
      chk("rst_strobes", 64'({w_we, x_we, job_done}), 64'd0);
      chk("rst_data", data_bus, 64'd0);
      reset = 1'b1;
      tick;

      // num_rows=0 completes at once
      start_job(6'd0);
      chk("zero_job_done", 64'(job_done), 64'd1);
      chk("zero_job_busy", 64'(busy), 64'd0);
      tick;
      chk("zero_job_done_low", 64'(job_done), 64'd0);

      // weight load then dense row
      start_job(6'd1);
      chk("wl_busy", 64'(busy), 64'd1);
      chk("wl_w_ready", 64'(w_ready), 64'd1);
      load_w(1'b0);
      send_row(64'h0000_0000_0000_00F3);
      chk_beat("dense1", mk(0, 1, 4, 5), 64'hF3, 2'd3, 1'b0, 1'b0);
      tick;
      chk_beat("dense2", mk(6, 7, 0, 0), 64'hF3, 2'd1, 1'b1, 1'b1);
      tick;
      chk("dense_job_done", 64'(job_done), 64'd1);
      chk("dense_x_we_low", 64'(x_we), 64'd0);
      chk("dense_idle", 64'(busy), 64'd0);
      tick;
      chk("dense_job_done_low", 64'(job_done), 64'd0);

      // zero row then single top bit
      start_job(6'd2);
      load_w(1'b0);
      send_row(64'h0);
      chk_beat("zero_row", mk(0, 0, 0, 0), 64'h0, 2'd0, 1'b0, 1'b1);
      chk("zero_row_f_ready", 64'(f_ready), 64'd0);
      tick;
      chk("bubble_f_ready", 64'(f_ready), 64'd1);
      chk("bubble_x_we", 64'(x_we), 64'd0);
      send_row(64'h8000_0000_0000_0000);
      chk_beat("bit63", mk(63, 0, 0, 0), 64'h8000_0000_0000_0000, 2'd0, 1'b0, 1'b1);
      tick;
      chk("zs_job_done", 64'(job_done), 64'd1);
      tick;

      // full row: 16 beats
      start_job(6'd1);
      load_w(1'b0);
      send_row(64'hFFFF_FFFF_FFFF_FFFF);
      for (int b = 0; b < 16; b++) begin
         chk_beat("full", mk(4*b, 4*b+1, 4*b+2, 4*b+3), 64'hFFFF_FFFF_FFFF_FFFF,
                  2'd3, 1'(b != 0), 1'(b == 15));
         chk("full_f_ready", 64'(f_ready), 64'd0);
         tick;
      end
      chk("full_job_done", 64'(job_done), 64'd1);
      tick;

      // gaps on both streams, three rows, stray start while busy
      start_job(6'd3);
      load_w(1'b1);
      send_row(64'h0000_0000_0000_0100);
      chk_beat("gapA", mk(8, 0, 0, 0), 64'h100, 2'd0, 1'b0, 1'b1);
      for (int g = 0; g < 3; g++) begin
         tick;
         chk("gap1_x_we", 64'(x_we), 64'd0);
         chk("gap1_job_done", 64'(job_done), 64'd0);
      end
      send_row(64'h0000_0000_0000_001F);
      chk_beat("gapB1", mk(0, 1, 2, 3), 64'h1F, 2'd3, 1'b0, 1'b0);
      tick;
      chk_beat("gapB2", mk(4, 0, 0, 0), 64'h1F, 2'd0, 1'b1, 1'b1);
      start    = 1'b1;
      num_rows = 6'd0;
      for (int g = 0; g < 3; g++) begin
         tick;
         start = 1'b0;
         chk("gap2_x_we", 64'(x_we), 64'd0);
         chk("gap2_job_done", 64'(job_done), 64'd0);
         chk("gap2_busy", 64'(busy), 64'd1);
      end
      send_row(64'h8000_0000_0000_0001);
      chk_beat("gapC", mk(0, 63, 0, 0), 64'h8000_0000_0000_0001, 2'd1, 1'b0, 1'b1);
      tick;
      chk("gap_job_done", 64'(job_done), 64'd1);
      tick;

      // async reset during the second beat of a row
      start_job(6'd1);
      load_w(1'b0);
      send_row(64'hFFFF_FFFF_FFFF_FFFF);
      tick;
      chk("pre_rst_x_we", 64'(x_we), 64'd1);
      reset = 1'b0;
      #1;
      chk("arst_x_we", 64'(x_we), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_addr", 64'(addr_bus), 64'd0);
      chk("arst_data", data_bus, 64'd0);
      chk("arst_ctl", 64'({non_zero_num, acc, done, f_ready, w_ready}), 64'd0);
      tick;
      tick;
      reset = 1'b1;
      tick;
      chk("post_rst_strobes", 64'({w_we, x_we, job_done}), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
      start_job(6'd1);
      load_w(1'b0);
      send_row(64'h0000_0000_0000_00F3);
      chk_beat("again1", mk(0, 1, 4, 5), 64'hF3, 2'd3, 1'b0, 1'b0);
      tick;
      chk_beat("again2", mk(6, 7, 0, 0), 64'hF3, 2'd1, 1'b1, 1'b1);
      tick;
      chk("again_job_done", 64'(job_done), 64'd1);
      tick;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pe_feeder.md
Name: pe_feeder

Overview:
- Upstream driver for the 4-lane sparse PE top (the PE with the MAC_DIM=4 non-zero address bus).
- Loads the PE weight scratchpad with WGT_WIDTH weight beats.
- Streams binary feature rows: extracts non-zero bit positions and issues them MAC_DIM per beat with matching non_zero_num/acc/done.
- Sits between the feature/weight fetch FIFOs and the PE top. Drives that block's addr_bus, data_bus, non_zero_num, acc, done, w_we and x_we.

Parameters:
- MAC_DIM, 4: non-zero indices per beat. Fixed at 4, since non_zero_num is 2 bits.
- FEAT_WIDTH, 1: feature bit width. Only 1 is supported.
- WGT_WIDTH, 8: weight width. It also sets the number of weight write beats.
- SPAD_WIDTH, 64: features per row, and data_bus width.
- NUM_NODES, 20: maximum rows per job.
- ADDR_WIDTH, C_LOG_2(SPAD_WIDTH): width of one non-zero index.
- WGT_INDEX, C_LOG_2(WGT_WIDTH): width of the weight beat index.
- NODE_W, C_LOG_2(NUM_NODES)+1: width of the row counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  job start pulse. Sampled only in IDLE.
- num_rows  in  NODE_W  rows in this job. Latched on start. Valid range 1..NUM_NODES.
- w_valid  in  1  weight beat valid.
- w_data  in  SPAD_WIDTH  weight beat: WGT_WIDTH-bit weights, packed LSB-first.
- w_ready  out  1  weight beat accept.
- f_valid  in  1  feature row valid.
- f_data  in  SPAD_WIDTH  binary feature row.
- f_ready  out  1  feature row accept.
- addr_bus  out  ADDR_WIDTH*MAC_DIM  non-zero indices, slot k at [ADDR_WIDTH*k +: ADDR_WIDTH]. In weight phase, bits [WGT_INDEX-1:0] carry the beat index.
- data_bus  out  SPAD_WIDTH  weight beat or feature row.
- non_zero_num  out  2  valid slots in the beat, minus 1.
- acc  out  1  accumulate into the running sum. 0 on the first beat of a row.
- done  out  1  last beat of a row.
- w_we  out  1  weight write strobe.
- x_we  out  1  feature beat strobe.
- busy  out  1  high when not in IDLE.
- job_done  out  1  one-cycle pulse after the last beat of the last row.

Behaviour:
- All outputs are registered. While reset is low, every output is 0 and the FSM is in IDLE.
- A reset that falls mid-job aborts the job immediately. No partial strobes are emitted after reset is released.
- FSM states: IDLE, WLOAD, FEAT.
- IDLE:
  - w_ready=0, f_ready=0.
  - start=1 latches num_rows, clears the counters and moves to WLOAD.
  - start while busy is ignored.
  - num_rows=0 goes straight from IDLE to IDLE and pulses job_done the next cycle.
- WLOAD:
  - w_ready=1.
  - On each handshake at cycle T, at T+1: w_we=1, data_bus=w_data, addr_bus[WGT_INDEX-1:0]=wcnt, all other addr bits 0, x_we=0.
  - wcnt counts 0..WGT_WIDTH-1. After the WGT_WIDTH-th handshake the FSM moves to FEAT; w_ready drops in the same cycle the last strobe is issued.
  - Gaps in w_valid insert idle cycles: w_we=0, all other outputs hold.
- FEAT:
  - f_ready = row_empty. A new row is accepted only when no mask bits remain.
  - On handshake, mask<=f_data and row<=f_data are captured, and first<=1.
  - Each following cycle, the lowest min(4, popcount(mask)) set bits are extracted in ascending order into slots 0..n-1. Unused slots are 0.
  - Each such cycle emits x_we=1, data_bus=row, non_zero_num=n-1, acc=~first, done=(remaining mask==0). The extracted bits are cleared and first<=0.
  - An all-zero row emits exactly one beat: slots all 0, non_zero_num=0, acc=0, done=1. The PE then multiplies by feature bit 0, giving 0.
  - Latency: handshake at T gives the first beat at T+1. A row with k non-zeros takes ceil(k/4) beats, or 1 if k=0.
  - f_ready reasserts the cycle after the done beat, so there is one bubble between rows.
  - rcnt increments on each done beat. When rcnt reaches num_rows: FSM to IDLE, job_done=1 for 1 cycle on the cycle after the last done beat.
- x_we and w_we are never high together. acc/done/non_zero_num/addr_bus are meaningful only with x_we; they hold their last value otherwise.

Decomposition:
- Shared package (log2.vh plus a pe_feeder defines header): FSM state encodings (IDLE=2'd0, WLOAD=2'd1, FEAT=2'd2), MAC_DIM and the non_zero_num encoding (count-1).
- Sub-module nz_extract4: purely combinational.
  - Input: SPAD_WIDTH-bit mask.
  - Outputs: four ADDR_WIDTH indices, 3-bit count (0..4) and the next mask.
  - Built as a chain of four lowest-set-bit priority encoders.

Test Plan:
- Weight load: start with num_rows=1, then 8 w beats with w_data=64'h0807060504030201+i. Expect 8 w_we pulses, addr_bus[2:0]=0..7 in order, data_bus equal to each beat, and f_ready high after the 8th.
- Dense row: f_data=64'h0000_0000_0000_00F3 (bits 0,1,4,5,6,7). Expect beat1 slots {0,1,4,5}, nzn=3, acc=0, done=0. Then beat2 slots {6,7,0,0}, nzn=1, acc=1, done=1. Then job_done.
- Zero row and single bit: rows 64'h0 then 64'h8000_0000_0000_0000. Expect beat nzn=0, acc=0, done=1; then beat slot0=63, nzn=0, acc=0, done=1.
- Full row 64'hFFFF_FFFF_FFFF_FFFF. Expect 16 beats, indices 0..63 ascending, acc=0 only on beat 1, done only on beat 16, f_ready low throughout.
- Backpressure and gaps: w_valid toggling every other cycle, and f_valid low for 3 cycles between rows. Expect no extra strobes, correct counts, and job_done only after num_rows=3 done beats.
- Reset mid-FEAT: assert reset during the 2nd beat of a row. Expect all outputs 0 asynchronously, busy=0, and a fresh start runs correctly.
